// File: rtl/fan_speed_ctrl.sv
// Four-speed fan controller: button-driven OFF/LOW/MID/HIGH state, PWM drive whose duty changes only at period boundaries.
// Optional soft start (rate-limited duty ramp) is enabled by defining FAN_SOFT_START_EN.
module fan_speed_ctrl #(
   parameter int PERIOD    = 1000,
   parameter int DUTY_LOW  = 300,
   parameter int DUTY_MID  = 600,
   parameter int DUTY_HIGH = 900,
   parameter int RAMP_STEP = 50
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_btn_up,
   input  logic       i_btn_down,
   input  logic       i_btn_off,
   output logic       o_pwm,
   output logic [1:0] o_speed,
   output logic [9:0] o_duty,
   output logic       o_ramping
);

   typedef enum logic [1:0] {S_OFF = 2'd0, S_LOW = 2'd1, S_MID = 2'd2, S_HIGH = 2'd3} state_t;

   state_t      state_q, state_d;
   logic [9:0]  cnt_q, cnt_d;
   logic [9:0]  duty_q, duty_d;
   logic [9:0]  target;
   logic        period_end;

`ifdef FAN_SOFT_START_EN
   localparam logic signed [11:0] STEP_S = 12'(RAMP_STEP);
   localparam logic [10:0]        STEP_U = 11'(RAMP_STEP);

   // Moves cur toward tgt by at most RAMP_STEP; the signed 12-bit difference cannot wrap.
   function automatic logic [9:0] ramp_toward(input logic [9:0] cur, input logic [9:0] tgt);
      logic signed [11:0] diff;
      logic [10:0]        sum;
      logic [10:0]        dif;
      diff = $signed({2'b00, tgt}) - $signed({2'b00, cur});
      sum  = {1'b0, cur} + STEP_U;
      dif  = {1'b0, cur} - STEP_U;
      if (diff > STEP_S)
         ramp_toward = sum[9:0];
      else if (diff < -STEP_S)
         ramp_toward = dif[9:0];
      else
         ramp_toward = tgt;
   endfunction
`endif

   assign period_end = (cnt_q == 10'(PERIOD - 1));

   always_comb begin
      state_d = state_q;
      if (i_btn_off) begin
         state_d = S_OFF;
      end else if (i_btn_up && !i_btn_down) begin
         case (state_q)
            S_OFF:   state_d = S_LOW;
            S_LOW:   state_d = S_MID;
            default: state_d = S_HIGH;
         endcase
      end else if (i_btn_down && !i_btn_up) begin
         case (state_q)
            S_HIGH:  state_d = S_MID;
            S_MID:   state_d = S_LOW;
            default: state_d = S_OFF;
         endcase
      end
   end

   always_comb begin
      target = 10'd0;
      case (state_q)
         S_LOW:   target = 10'(DUTY_LOW);
         S_MID:   target = 10'(DUTY_MID);
         S_HIGH:  target = 10'(DUTY_HIGH);
         default: target = 10'd0;
      endcase
   end

   always_comb begin
      cnt_d  = period_end ? 10'd0 : cnt_q + 10'd1;
      duty_d = duty_q;
      // Duty is latched only at the wrap so each PWM period uses one constant value.
      if (period_end) begin
`ifdef FAN_SOFT_START_EN
         duty_d = ramp_toward(duty_q, target);
`else
         duty_d = target;
`endif
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q <= S_OFF;
         cnt_q   <= 10'd0;
         duty_q  <= 10'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         duty_q  <= duty_d;
      end
   end

   assign o_pwm     = (cnt_q < duty_q);
   assign o_speed   = state_q;
   assign o_duty    = duty_q;
   assign o_ramping = (duty_q != target);

endmodule

// File: tb/tb_fan_speed_ctrl.sv
// Directed bench for fan_speed_ctrl; expectations follow FAN_SOFT_START_EN when it is defined.
module tb_fan_speed_ctrl;
   logic       clk = 1'b0;
   logic       rst, up, down, off;
   logic       pwm;
   logic [1:0] speed;
   logic [9:0] duty;
   logic       ramping;

   int n_checks = 0;
   int n_fail   = 0;
   int ph       = 0;
   int highs;

   always #5 clk = ~clk;

   fan_speed_ctrl dut (
      .i_clk      (clk),
      .i_reset    (rst),
      .i_btn_up   (up),
      .i_btn_down (down),
      .i_btn_off  (off),
      .o_pwm      (pwm),
      .o_speed    (speed),
      .o_duty     (duty),
      .o_ramping  (ramping)
   );

   task automatic check(input string tag, input int obs, input int exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Advance one edge, then settle; ph mirrors the expected period counter.
   task automatic tick();
      @(posedge clk);
      #1;
      if (rst) ph = 0;
      else     ph = (ph + 1) % 1000;
   endtask

   task automatic pulse(input logic u, input logic d, input logic o);
      up = u; down = d; off = o;
      tick();
      up = 1'b0; down = 1'b0; off = 1'b0;
   endtask

   task automatic next_boundary();
      tick();
      while (ph != 0) tick();
   endtask

   task automatic count_highs(input int n);
      highs = 0;
      for (int i = 0; i < n; i++) begin
         if (pwm) highs++;
         tick();
      end
   endtask

   initial begin
      rst = 1'b1; up = 1'b1; down = 1'b0; off = 1'b0;
      tick();
      tick();
      check("reset_pwm", pwm, 0);
      check("reset_speed", speed, 0);
      check("reset_duty", duty, 0);
      check("reset_ramping", ramping, 0);
      rst = 1'b0; up = 1'b0;

      count_highs(2000);
      check("idle_pwm_highs", highs, 0);
      check("idle_speed", speed, 0);
      check("idle_duty", duty, 0);

      pulse(1'b1, 1'b0, 1'b0);
      check("up_off_to_low", speed, 1);
      check("low_ramping_before_boundary", ramping, 1);
      check("low_duty_before_boundary", duty, 0);
`ifdef FAN_SOFT_START_EN
      for (int k = 1; k <= 6; k++) begin
         next_boundary();
         check("low_ramp_step", duty, 50 * k);
      end
`else
      next_boundary();
      check("low_duty_loaded", duty, 300);
`endif
      check("low_settled", ramping, 0);
      count_highs(1000);
      check("low_pwm_highs", highs, 300);

      pulse(1'b1, 1'b0, 1'b0);
      pulse(1'b1, 1'b0, 1'b0);
      check("up_to_high", speed, 3);
`ifdef FAN_SOFT_START_EN
      for (int k = 1; k <= 12; k++) next_boundary();
`else
      next_boundary();
`endif
      check("high_duty", duty, 900);
      check("high_settled", ramping, 0);
      pulse(1'b1, 1'b0, 1'b0);
      check("up_in_high_stays", speed, 3);
      pulse(1'b0, 1'b0, 1'b1);
      check("off_from_high", speed, 0);
      check("off_ramping", ramping, 1);
`ifdef FAN_SOFT_START_EN
      for (int k = 1; k <= 18; k++) begin
         next_boundary();
         check("off_ramp_down", duty, 900 - 50 * k);
      end
`else
      next_boundary();
      check("off_duty_loaded", duty, 0);
`endif
      check("off_settled", ramping, 0);

      pulse(1'b1, 1'b0, 1'b0);
      pulse(1'b1, 1'b0, 1'b0);
      check("up_to_mid", speed, 2);
      pulse(1'b1, 1'b1, 1'b0);
      check("up_down_ignored", speed, 2);
      pulse(1'b0, 1'b1, 1'b0);
      check("down_mid_to_low", speed, 1);
      pulse(1'b1, 1'b0, 1'b1);
      check("up_off_gives_off", speed, 0);
      pulse(1'b0, 1'b1, 1'b0);
      check("down_in_off_stays", speed, 0);
      next_boundary();
      check("back_to_zero", duty, 0);

`ifdef FAN_SOFT_START_EN
      pulse(1'b1, 1'b0, 1'b0);
      for (int k = 1; k <= 3; k++) next_boundary();
      check("midramp_duty", duty, 150);
      pulse(1'b1, 1'b0, 1'b0);
      pulse(1'b1, 1'b0, 1'b0);
      check("redirect_speed", speed, 3);
      for (int k = 1; k <= 15; k++) begin
         next_boundary();
         check("redirect_ramp", duty, 150 + 50 * k);
      end
      next_boundary();
      check("no_overshoot", duty, 900);
      check("redirect_settled", ramping, 0);
`else
      pulse(1'b1, 1'b0, 1'b0);
      pulse(1'b1, 1'b0, 1'b0);
      next_boundary();
      check("off_to_mid_one_period", duty, 600);
      check("mid_settled", ramping, 0);
`endif

      while (ph != 500) tick();
      check("pwm_high_at_500", pwm, 1);
      rst = 1'b1; up = 1'b1;
      tick();
      check("midperiod_reset_pwm", pwm, 0);
      check("midperiod_reset_speed", speed, 0);
      check("midperiod_reset_duty", duty, 0);
      check("midperiod_reset_ramping", ramping, 0);
      rst = 1'b0; up = 1'b0;
      pulse(1'b1, 1'b0, 1'b0);
      next_boundary();
`ifdef FAN_SOFT_START_EN
      check("post_reset_first_step", duty, 50);
`else
      check("post_reset_low_duty", duty, 300);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/fan_speed_ctrl.md
FAN_SPEED_CTRL -- requirements
Module: fan_speed_ctrl

Interface
REQ-001 SHALL have parameter PERIOD, default 1000, meaning PWM period in clocks (counter range 0..PERIOD-1).
REQ-002 SHALL have parameter DUTY_LOW, default 300, meaning duty target in LOW.
REQ-003 SHALL have parameter DUTY_MID, default 600, meaning duty target in MID.
REQ-004 SHALL have parameter DUTY_HIGH, default 900, meaning duty target in HIGH.
REQ-005 SHALL have parameter RAMP_STEP, default 50, meaning maximum duty change per PWM period.
REQ-006 SHALL have port i_clk, input, 1 bit: the single clock; all logic on rising edge.
REQ-007 SHALL have port i_reset, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have port i_btn_up, input, 1 bit: single-cycle, already-debounced speed-up request.
REQ-009 SHALL have port i_btn_down, input, 1 bit: single-cycle speed-down request.
REQ-010 SHALL have port i_btn_off, input, 1 bit: single-cycle stop request.
REQ-011 SHALL have port o_pwm, output, 1 bit: motor drive.
REQ-012 SHALL have port o_speed, output, 2 bits: speed state (0 OFF, 1 LOW, 2 MID, 3 HIGH).
REQ-013 SHALL have port o_duty, output, 10 bits: currently applied duty.
REQ-014 SHALL have port o_ramping, output, 1 bit: high while applied duty differs from target.

Function
REQ-015 SHALL hold a 10-bit period counter that counts 0..PERIOD-1 and wraps from PERIOD-1 to 0.
REQ-016 SHALL implement states OFF, LOW, MID, HIGH; o_speed SHALL equal the state register.
REQ-017 On i_btn_off, state SHALL go to OFF on the next edge, from any state.
REQ-018 On i_btn_up alone: OFF->LOW, LOW->MID, MID->HIGH, HIGH stays HIGH.
REQ-019 On i_btn_down alone: HIGH->MID, MID->LOW, LOW->OFF, OFF stays OFF.
REQ-020 Priority: i_btn_off over up/down; up and down in the same cycle without off SHALL be ignored.
REQ-021 The target duty SHALL be 0, DUTY_LOW, DUTY_MID or DUTY_HIGH for OFF, LOW, MID or HIGH.
REQ-022 The applied duty register SHALL update only on the edge where the counter equals PERIOD-1, so every PWM period uses one constant duty.
REQ-023 o_pwm SHALL be combinational: high exactly when counter < applied duty; duty 0 SHALL give a constantly low output.
REQ-024 Ramp arithmetic SHALL be at least 11 bits wide; each step SHALL move the duty toward the target by min(RAMP_STEP, |target-duty|), never overshooting and never wrapping.
REQ-025 A target change mid-ramp SHALL redirect the ramp at the next period boundary, starting from the current applied duty.
REQ-026 o_ramping SHALL equal (applied duty != target), combinational from registers.
REQ-027 Button pulses SHALL be accepted on any cycle, independent of the counter phase.

Reset
REQ-028 On an i_reset-high edge: counter 0, state OFF, applied duty 0; therefore o_pwm 0, o_speed 0, o_duty 0, o_ramping 0.
REQ-029 Reset SHALL override simultaneous button pulses, and a reset mid-ramp or mid-period SHALL leave no residual state.

Configuration
REQ-030 Macro FAN_SOFT_START_EN defined: applied duty ramps per REQ-024.
REQ-031 Macro FAN_SOFT_START_EN undefined: applied duty loads the full target at the next period boundary; o_ramping is high only from the target change until that boundary.

Verification
REQ-032 Reset, then 2000 idle clocks -> o_pwm stays 0, o_speed 0, o_duty 0.
REQ-033 With ramp, pulse up once from OFF -> o_speed 1 next edge; o_duty 50,100,...,300 over 6 boundaries; then 300 high clocks per 1000.
REQ-034 In HIGH (duty 900), pulse up -> stays HIGH; pulse off -> o_speed 0; duty ramps 850..0 over 18 periods.
REQ-035 Up and down in the same cycle in MID -> state unchanged; up+off in the same cycle -> OFF.
REQ-036 In LOW mid-ramp at duty 150, pulse up twice -> target 900; ramp continues 200,250,... with no overshoot at 900.
REQ-037 Macro undefined: OFF->MID in a single period; reset asserted at counter 500 -> all outputs 0 next edge.
